wb_arbiter: RTL

Write-back arbiter that owns the single write port of the 32x32 register file. It merges results from the single-cycle ALU pipeline, which has no backpressure, with results from slow producers (load unit, mul/div) that arrive through a valid/ready handshake into a small FIFO. It serialises both streams onto `REG_address_wr`/`REG_write_1`/`REG_data_wb_in1`, and exports a busy mask so decode can stall on registers with a pending slow write.

---
 rtl/wb_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the register-file write port, giving single-cycle ALU results priority
// over slow results queued in a small FIFO. Queued entries that an ALU write overtakes are killed.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              SYS_reset,
  input  logic              WB_alu_valid,
  input  logic [4:0]        WB_alu_addr,
  input  logic [31:0]       WB_alu_data,
  input  logic              WB_mem_valid,
  output logic              WB_mem_ready,
  input  logic [4:0]        WB_mem_addr,
  input  logic [31:0]       WB_mem_data,
  output logic [4:0]        REG_address_wr,
  output logic              REG_write_1,
  output logic [31:0]       REG_data_wb_in1,
  output logic [31:0]       WB_busy_mask,
  output logic [CNT_W-1:0]  WB_count
);

  localparam int PTR_W = CNT_W - 1;

  logic              live_reg [DEPTH];
  logic [4:0]        addr_reg [DEPTH];
  logic [31:0]       data_reg [DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic alu_issue;
  logic fifo_empty;
  logic push;
  logic pop;

  assign alu_issue    = WB_alu_valid && (WB_alu_addr != 5'd0);
  assign fifo_empty   = (count_reg == '0);
  assign WB_mem_ready = SYS_reset && (count_reg < CNT_W'(DEPTH));
  // An address-0 handshake completes but occupies no slot.
  assign push         = WB_mem_valid && WB_mem_ready && (WB_mem_addr != 5'd0);
  assign pop          = !alu_issue && !fifo_empty;
  assign WB_count     = count_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  // The tail slot is always free when pushing, so a same-edge push overrides any kill match there.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_reg[i] <= 1'b0;
        addr_reg[i] <= 5'd0;
        data_reg[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail_reg == PTR_W'(i))) begin
          live_reg[i] <= 1'b1;
          addr_reg[i] <= WB_mem_addr;
          data_reg[i] <= WB_mem_data;
        end else if (pop && (head_reg == PTR_W'(i))) begin
          live_reg[i] <= 1'b0;
        end else if (alu_issue && (addr_reg[i] == WB_alu_addr)) begin
          live_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // A killed head still takes its slot; address and data are left as they were.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      REG_write_1     <= 1'b0;
      REG_address_wr  <= 5'd0;
      REG_data_wb_in1 <= 32'd0;
    end else if (alu_issue) begin
      REG_write_1     <= 1'b1;
      REG_address_wr  <= WB_alu_addr;
      REG_data_wb_in1 <= WB_alu_data;
    end else if (pop) begin
      REG_write_1 <= live_reg[head_reg];
      if (live_reg[head_reg]) begin
        REG_address_wr  <= addr_reg[head_reg];
        REG_data_wb_in1 <= data_reg[head_reg];
      end
    end else begin
      REG_write_1 <= 1'b0;
    end
  end

  logic [DEPTH-1:0][31:0] entry_mask;
  logic [31:0]            mask_all;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_mask
      assign entry_mask[gi] = live_reg[gi] ? (32'd1 << addr_reg[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    mask_all = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mask_all = mask_all | entry_mask[i];
    end
  end

  assign WB_busy_mask = {mask_all[31:1], 1'b0};

endmodule
